// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binary conv/pool datapath.
package bnn_pkg;

    function automatic int pc_width(input int n);
        return $clog2(n + 1);
    endfunction

    typedef enum logic {S_IDLE, S_RUN} bcp_state_t;

endpackage

// File: rtl/bin_conv_pool_if.sv
// Window stream into the conv/pool stage and pooled activations out of it.
interface bin_conv_pool_if #(
    parameter int NO_CH   = 2,
    parameter int WINDOW  = 3,
    parameter int NO_FILT = 8
);
    logic               vld_in;
    logic [NO_CH-1:0]   data_in [WINDOW-1:0];
    logic               vld_out;
    logic [NO_FILT-1:0] data_out;
    logic               frame_done;

    modport master (output vld_in, data_in, input vld_out, data_out, frame_done);
    modport slave  (input vld_in, data_in, output vld_out, data_out, frame_done);
endinterface

// File: rtl/popcount_tree.sv
// Combinational popcount built as a balanced binary adder tree.
module popcount_tree
    import bnn_pkg::*;
#(
    parameter int N = 6,
    localparam int W = pc_width(N)
) (
    input  logic [N-1:0] bits,
    output logic [W-1:0] count
);

    generate
        if (N == 1) begin : g_leaf
            assign count = bits;
        end else begin : g_node
            localparam int NL = N / 2;
            localparam int NR = N - NL;
            localparam int WL = pc_width(NL);
            localparam int WR = pc_width(NR);

            logic [WL-1:0] count_lo;
            logic [WR-1:0] count_hi;

            popcount_tree #(.N(NL)) u_lo (.bits(bits[NL-1:0]), .count(count_lo));
            popcount_tree #(.N(NR)) u_hi (.bits(bits[N-1:NL]), .count(count_hi));

            assign count = W'(count_lo) + W'(count_hi);
        end
    endgenerate

endmodule

// File: rtl/bin_conv_pool.sv
// Binary conv (XNOR-popcount + threshold) followed by OR max-pool and frame tracking.
module bin_conv_pool
    import bnn_pkg::*;
#(
    parameter int NO_CH         = 2,
    parameter int WINDOW        = 3,
    parameter int NO_FILT       = 8,
    parameter int POOL          = 2,
    parameter int LOG2_IMG_SIZE = 10,
    localparam int PC_W         = pc_width(NO_CH * WINDOW)
) (
    input  logic                      clk,
    input  logic                      rst,
    bin_conv_pool_if.slave            bus,
    input  logic [NO_CH*WINDOW-1:0]   weights    [NO_FILT-1:0],
    input  logic [PC_W-1:0]           thresholds [NO_FILT-1:0]
);

    localparam int NBITS = NO_CH * WINDOW;
    localparam int CNT_W = (POOL > 1) ? $clog2(POOL) : 1;
    localparam logic [CNT_W-1:0]         POOL_LAST = CNT_W'(POOL - 1);
    localparam logic [LOG2_IMG_SIZE-1:0] WIN_LAST  = '1;

    logic [NBITS-1:0]   flat;
    logic [PC_W-1:0]    match_c [NO_FILT-1:0];
    logic [PC_W-1:0]    match_q [NO_FILT-1:0];
    logic               v1;
    logic [NO_FILT-1:0] act_q;
    logic               v2;

    logic [NO_FILT-1:0] pool_acc;
    logic [NO_FILT-1:0] pool_sum;
    logic [CNT_W-1:0]   pool_cnt;

    bcp_state_t               state, state_n;
    logic [LOG2_IMG_SIZE-1:0] win_cnt, win_cnt_n;
    logic                     frame_done_n;
    logic                     frame_last;

    always_comb begin
        flat = '0;
        for (int w = 0; w < WINDOW; w++) begin
            for (int c = 0; c < NO_CH; c++) begin
                flat[w*NO_CH+c] = bus.data_in[w][c];
            end
        end
    end

    generate
        for (genvar f = 0; f < NO_FILT; f++) begin : g_filt
            logic [NBITS-1:0] agree;
            assign agree = ~(flat ^ weights[f]);
            popcount_tree #(.N(NBITS)) u_pc (.bits(agree), .count(match_c[f]));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            for (int f = 0; f < NO_FILT; f++) match_q[f] <= '0;
        end else begin
            v1 <= bus.vld_in;
            for (int f = 0; f < NO_FILT; f++) match_q[f] <= match_c[f];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2    <= 1'b0;
            act_q <= '0;
        end else begin
            v2 <= v1;
            for (int f = 0; f < NO_FILT; f++) act_q[f] <= (match_q[f] >= thresholds[f]);
        end
    end

    // The first window of a group replaces the accumulator rather than ORing into stale data.
    assign pool_sum   = (pool_cnt == '0) ? act_q : (pool_acc | act_q);
    assign frame_last = v2 && (win_cnt == WIN_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pool_acc     <= '0;
            pool_cnt     <= '0;
            bus.vld_out  <= 1'b0;
            bus.data_out <= '0;
        end else begin
            bus.vld_out <= 1'b0;
            if (v2) begin
                pool_acc <= pool_sum;
                if (pool_cnt == POOL_LAST) begin
                    bus.data_out <= pool_sum;
                    bus.vld_out  <= 1'b1;
                    pool_cnt     <= '0;
                end else begin
                    pool_cnt <= pool_cnt + CNT_W'(1);
                end
                if (frame_last) pool_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            win_cnt        <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            state          <= state_n;
            win_cnt        <= win_cnt_n;
            bus.frame_done <= frame_done_n;
        end
    end

    // Frame wrap wins over the IDLE->RUN step so a one-window frame still terminates.
    always_comb begin
        state_n      = state;
        win_cnt_n    = win_cnt;
        frame_done_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (v2) begin
                    if (frame_last) begin
                        win_cnt_n    = '0;
                        frame_done_n = 1'b1;
                    end else begin
                        state_n   = S_RUN;
                        win_cnt_n = LOG2_IMG_SIZE'(1);
                    end
                end
            end
            S_RUN: begin
                if (v2) begin
                    if (frame_last) begin
                        state_n      = S_IDLE;
                        win_cnt_n    = '0;
                        frame_done_n = 1'b1;
                    end else begin
                        win_cnt_n = win_cnt + LOG2_IMG_SIZE'(1);
                    end
                end
            end
            default: begin
                state_n   = S_IDLE;
                win_cnt_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_bin_conv_pool.sv
// Self-checking bench: random windows against a window-level model plus hand-computed scenarios.
module tb_bin_conv_pool;
    import bnn_pkg::*;

    localparam int NO_CH         = 2;
    localparam int WINDOW        = 3;
    localparam int NO_FILT       = 8;
    localparam int POOL          = 2;
    localparam int LOG2_IMG_SIZE = 3;
    localparam int NBITS         = NO_CH * WINDOW;
    localparam int PC_W          = pc_width(NBITS);
    localparam int FRAME         = 2 ** LOG2_IMG_SIZE;

    typedef struct {
        logic [NO_FILT-1:0] data;
        logic               fd;
        int                 due;
    } exp_t;

    logic clk;
    logic rst;
    logic [NBITS-1:0] weights    [NO_FILT-1:0];
    logic [PC_W-1:0]  thresholds [NO_FILT-1:0];

    bin_conv_pool_if #(.NO_CH(NO_CH), .WINDOW(WINDOW), .NO_FILT(NO_FILT)) bus ();

    bin_conv_pool #(
        .NO_CH(NO_CH), .WINDOW(WINDOW), .NO_FILT(NO_FILT),
        .POOL(POOL), .LOG2_IMG_SIZE(LOG2_IMG_SIZE)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .weights(weights), .thresholds(thresholds)
    );

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;
    exp_t exp_q[$];
    logic [NO_FILT-1:0] last_data = '0;
    int pulse_cnt = 0;
    logic [31:0] fd_mask = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [NO_FILT-1:0] model_act(input logic [NBITS-1:0] bits);
        logic [NO_FILT-1:0] act;
        act = '0;
        for (int f = 0; f < NO_FILT; f++) begin
            int m;
            m = 0;
            for (int i = 0; i < NBITS; i++) if (bits[i] == weights[f][i]) m++;
            act[f] = (m >= int'(thresholds[f]));
        end
        return act;
    endfunction

    // Window-level model: every POOL accepted windows form one group, due two edges after the last one.
    initial begin
        logic [NO_FILT-1:0] grp_acc;
        logic [NBITS-1:0]   fb;
        int grp_n;
        int frm_n;
        grp_acc = '0;
        grp_n   = 0;
        frm_n   = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                exp_q.delete();
                grp_acc = '0;
                grp_n   = 0;
                frm_n   = 0;
            end else begin
                edge_cnt++;
                if (bus.vld_in) begin
                    for (int w = 0; w < WINDOW; w++)
                        for (int c = 0; c < NO_CH; c++) fb[w*NO_CH+c] = bus.data_in[w][c];
                    grp_acc = grp_acc | model_act(fb);
                    grp_n++;
                    frm_n++;
                    if (grp_n == POOL) begin
                        exp_q.push_back('{grp_acc, (frm_n == FRAME), edge_cnt + 2});
                        grp_acc = '0;
                        grp_n   = 0;
                    end
                    if (frm_n == FRAME) frm_n = 0;
                end
            end
        end
    end

    initial begin
        logic exp_v;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_data = '0;
                check_output("rst vld_out", 32'(bus.vld_out), 32'd0);
                check_output("rst data_out", 32'(bus.data_out), 32'd0);
                check_output("rst frame_done", 32'(bus.frame_done), 32'd0);
            end else begin
                exp_v = (exp_q.size() > 0) && (exp_q[0].due == edge_cnt);
                check_output("vld_out", 32'(bus.vld_out), 32'(exp_v));
                if (exp_v) begin
                    check_output("data_out", 32'(bus.data_out), 32'(exp_q[0].data));
                    check_output("frame_done", 32'(bus.frame_done), 32'(exp_q[0].fd));
                    last_data = exp_q[0].data;
                    void'(exp_q.pop_front());
                end else begin
                    check_output("frame_done idle", 32'(bus.frame_done), 32'd0);
                    check_output("data_out hold", 32'(bus.data_out), 32'(last_data));
                end
                if (bus.vld_out) begin
                    pulse_cnt++;
                    if (bus.frame_done && pulse_cnt <= 32) fd_mask[pulse_cnt-1] = 1'b1;
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [NBITS-1:0] bits);
        for (int w = 0; w < WINDOW; w++)
            for (int c = 0; c < NO_CH; c++) bus.data_in[w][c] = bits[w*NO_CH+c];
        bus.vld_in = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.vld_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse(output int lat);
        bus.vld_in = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.vld_out) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_all(input logic [NBITS-1:0] w, input logic [PC_W-1:0] t);
        for (int f = 0; f < NO_FILT; f++) begin
            weights[f]    = w;
            thresholds[f] = t;
        end
    endtask

    initial begin
        int lat;
        int p0;
        rst = 1'b1;
        bus.vld_in = 1'b0;
        for (int w = 0; w < WINDOW; w++) bus.data_in[w] = '0;
        set_all('0, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);

        // All-zero data against all-zero weights: every filter matches 6 >= 4.
        set_all('0, PC_W'(4));
        apply_stimulus(6'b000000);
        apply_stimulus(6'b000000);
        wait_pulse(lat);
        check_output("t1 latency", 32'(lat), 32'd2);
        check_output("t1 data", 32'(bus.data_out), 32'hFF);
        idle(2);

        do_reset();
        set_all(6'b111111, PC_W'(6));
        weights[0] = 6'b000000;
        apply_stimulus(6'b111111);
        apply_stimulus(6'b111111);
        wait_pulse(lat);
        check_output("t2a data", 32'(bus.data_out), 32'hFE);
        weights[0] = 6'b000111;
        apply_stimulus(6'b111111);
        apply_stimulus(6'b111111);
        wait_pulse(lat);
        check_output("t2b data", 32'(bus.data_out), 32'hFE);
        idle(2);

        // Distinct weights per filter: only an exact window match reaches threshold 6.
        do_reset();
        for (int f = 0; f < NO_FILT; f++) begin
            weights[f]    = NBITS'(f * 9 + 1);
            thresholds[f] = PC_W'(6);
        end
        apply_stimulus(weights[1]);
        idle(2);
        apply_stimulus(weights[5]);
        wait_pulse(lat);
        check_output("t3 latency", 32'(lat), 32'd2);
        check_output("t3 data", 32'(bus.data_out), 32'h22);
        idle(2);

        do_reset();
        pulse_cnt = 0;
        fd_mask   = '0;
        for (int i = 0; i < 2 * FRAME; i++) apply_stimulus(NBITS'($urandom));
        idle(4);
        check_output("t4 pulses", 32'(pulse_cnt), 32'd8);
        check_output("t4 frame_done mask", fd_mask, 32'h88);

        do_reset();
        set_all('0, '0);
        apply_stimulus(NBITS'($urandom));
        apply_stimulus(NBITS'($urandom));
        wait_pulse(lat);
        check_output("t5 pre data", 32'(bus.data_out), 32'hFF);
        apply_stimulus(NBITS'($urandom));
        #2 rst = 1'b1;
        #1;
        check_output("t5 async vld_out", 32'(bus.vld_out), 32'd0);
        check_output("t5 async data_out", 32'(bus.data_out), 32'd0);
        check_output("t5 async frame_done", 32'(bus.frame_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int f = 0; f < NO_FILT; f++) begin
            weights[f]    = NBITS'(f * 9 + 1);
            thresholds[f] = PC_W'(6);
        end
        p0 = pulse_cnt;
        apply_stimulus(weights[2]);
        apply_stimulus(weights[2]);
        wait_pulse(lat);
        check_output("t5 latency", 32'(lat), 32'd2);
        check_output("t5 data", 32'(bus.data_out), 32'h04);
        idle(6);
        check_output("t5 pulse count", 32'(pulse_cnt - p0), 32'd1);

        set_all(NBITS'($urandom), '0);
        apply_stimulus(NBITS'($urandom));
        apply_stimulus(NBITS'($urandom));
        wait_pulse(lat);
        check_output("t6 thr0 data", 32'(bus.data_out), 32'hFF);
        set_all(NBITS'($urandom), PC_W'(7));
        apply_stimulus(NBITS'($urandom));
        apply_stimulus(NBITS'($urandom));
        wait_pulse(lat);
        check_output("t6 thr7 data", 32'(bus.data_out), 32'h00);
        idle(2);

        // Random windows with bubbles; weights and thresholds change only with the pipe drained.
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 0) begin
                idle(4);
                for (int f = 0; f < NO_FILT; f++) begin
                    weights[f]    = NBITS'($urandom);
                    thresholds[f] = PC_W'($urandom_range(0, 7));
                end
            end
            if ($urandom_range(0, 3) == 0) idle(1);
            else apply_stimulus(NBITS'($urandom));
        end
        idle(6);
        check_output("model queue drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
